// File: rtl/vga_scan_ctrl.sv
// vga_scan_ctrl: VGA raw scan counters, sync/blank decode through a
// PIPE_LAT-deep pipeline, colour gating, frame pulse and frame-stable scroll.
module vga_scan_ctrl #(
   parameter int H_ACTIVE = 640,
   parameter int H_FP     = 16,
   parameter int H_SYNC   = 96,
   parameter int H_BP     = 48,
   parameter int V_ACTIVE = 480,
   parameter int V_FP     = 10,
   parameter int V_SYNC   = 2,
   parameter int V_BP     = 33,
   parameter int PIPE_LAT = 1
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       pix_en,
   input  logic [7:0] r_in,
   input  logic [7:0] g_in,
   input  logic [7:0] b_in,
   input  logic [9:0] scroll_in,
   input  logic       scroll_wr,
   output logic [9:0] x,
   output logic [9:0] y,
   output logic [9:0] scroll_x,
   output logic       hsync,
   output logic       vsync,
   output logic       blank_n,
   output logic [7:0] vga_r,
   output logic [7:0] vga_g,
   output logic [7:0] vga_b,
   output logic       frame_start
);
   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
   localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);
   localparam logic [9:0] H_ACT  = 10'(H_ACTIVE);
   localparam logic [9:0] V_ACT  = 10'(V_ACTIVE);
   localparam logic [9:0] HS_ON  = 10'(H_ACTIVE + H_FP);
   localparam logic [9:0] HS_OFF = 10'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [9:0] VS_ON  = 10'(V_ACTIVE + V_FP);
   localparam logic [9:0] VS_OFF = 10'(V_ACTIVE + V_FP + V_SYNC);

   logic [9:0]          r_hc, r_vc, r_pend, r_scroll;
   logic                r_pend_v, r_fs;
   logic [PIPE_LAT-1:0] r_act, r_hs, r_vs;
   logic [7:0]          r_r, r_g, r_b;
   logic                w_h_end, w_v_end, w_wrap, w_active, w_hs, w_vs, w_gate;

   always_comb begin
      w_h_end  = r_hc == H_LAST;
      w_v_end  = r_vc == V_LAST;
      w_wrap   = pix_en && w_h_end && w_v_end;
      w_active = (r_hc < H_ACT) && (r_vc < V_ACT);
      w_hs     = !((r_hc >= HS_ON) && (r_hc < HS_OFF));
      w_vs     = !((r_vc >= VS_ON) && (r_vc < VS_OFF));
      // active value about to enter the last stage, so colour lines up with blank_n
      w_gate   = w_active;
      for (int i = 0; i < PIPE_LAT - 1; i++) w_gate = r_act[i];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_hc     <= '0;
         r_vc     <= '0;
         r_pend   <= '0;
         r_pend_v <= 1'b0;
         r_scroll <= '0;
         r_fs     <= 1'b0;
         r_act    <= '0;
         r_hs     <= '1;
         r_vs     <= '1;
         r_r      <= '0;
         r_g      <= '0;
         r_b      <= '0;
      end else begin
         r_fs <= w_wrap;
         if (pix_en) begin
            r_hc <= w_h_end ? '0 : r_hc + 10'd1;
            if (w_h_end) r_vc <= w_v_end ? '0 : r_vc + 10'd1;
            for (int i = PIPE_LAT - 1; i > 0; i--) begin
               r_act[i] <= r_act[i-1];
               r_hs[i]  <= r_hs[i-1];
               r_vs[i]  <= r_vs[i-1];
            end
            r_act[0] <= w_active;
            r_hs[0]  <= w_hs;
            r_vs[0]  <= w_vs;
            r_r      <= w_gate ? r_in : '0;
            r_g      <= w_gate ? g_in : '0;
            r_b      <= w_gate ? b_in : '0;
         end
         // a write landing on the wrap strobe bypasses the pending register
         if (w_wrap && scroll_wr) begin
            r_scroll <= scroll_in;
            r_pend_v <= 1'b0;
         end else begin
            if (w_wrap && r_pend_v) begin
               r_scroll <= r_pend;
               r_pend_v <= 1'b0;
            end
            if (scroll_wr) begin
               r_pend   <= scroll_in;
               r_pend_v <= 1'b1;
            end
         end
      end
   end

   assign x           = r_hc;
   assign y           = r_vc;
   assign scroll_x    = r_scroll;
   assign hsync       = r_hs[PIPE_LAT-1];
   assign vsync       = r_vs[PIPE_LAT-1];
   assign blank_n     = r_act[PIPE_LAT-1];
   assign vga_r       = r_r;
   assign vga_g       = r_g;
   assign vga_b       = r_b;
   assign frame_start = r_fs;
endmodule

// File: tb/tb_vga_scan_ctrl.sv
// tb_vga_scan_ctrl: directed bench on a reduced 15x8 raster (active 8x4,
// hsync hc 10..12, vsync vc 5..6) with a two-stage decode pipeline.
module tb_vga_scan_ctrl;
   logic       clk = 1'b0, rst_n = 1'b1, pix_en = 1'b0, scroll_wr = 1'b0;
   logic [7:0] r_in = 8'hFF, g_in = 8'h80, b_in = 8'h01;
   logic [9:0] scroll_in = '0;
   logic [9:0] x, y, scroll_x;
   logic       hsync, vsync, blank_n, frame_start;
   logic [7:0] vga_r, vga_g, vga_b;
   int n_pass = 0, n_total = 0;
   int hs_lo = 0, vs_lo = 0, bl = 0, bad = 0, fs_n = 0, fs1 = 0, fs2 = 0;
   int hs_first = 0, vs_first = 0, bl_fall = 0, fs_n2 = 0, fs_k = 0;

   always #5 clk = ~clk;

   vga_scan_ctrl #(
      .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
      .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1), .PIPE_LAT(2)
   ) dut (
      .clk(clk), .rst_n(rst_n), .pix_en(pix_en),
      .r_in(r_in), .g_in(g_in), .b_in(b_in),
      .scroll_in(scroll_in), .scroll_wr(scroll_wr),
      .x(x), .y(y), .scroll_x(scroll_x),
      .hsync(hsync), .vsync(vsync), .blank_n(blank_n),
      .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
      .frame_start(frame_start)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
   endtask

   initial begin
      #1 rst_n = 1'b0;
      #1;
      chk("rst_x", 32'(x), 0);
      chk("rst_y", 32'(y), 0);
      chk("rst_hsync", 32'(hsync), 1);
      chk("rst_vsync", 32'(vsync), 1);
      chk("rst_blank", 32'(blank_n), 0);
      chk("rst_rgb", 32'({vga_r, vga_g, vga_b}), 0);
      chk("rst_fs", 32'(frame_start), 0);
      chk("rst_scroll", 32'(scroll_x), 0);
      @(negedge clk);
      rst_n  = 1'b1;
      pix_en = 1'b1;
      for (int n = 1; n <= 240; n++) begin
         tick();
         if (!hsync) begin hs_lo++; if (hs_first == 0) hs_first = n; end
         if (!vsync) begin vs_lo++; if (vs_first == 0) vs_first = n; end
         if (blank_n) bl++;
         else if (bl > 0 && bl_fall == 0) bl_fall = n;
         if (blank_n ? {vga_r, vga_g, vga_b} !== 24'hFF8001 : {vga_r, vga_g, vga_b} !== 24'h0) bad++;
         if (frame_start) begin fs_n++; if (fs1 == 0) fs1 = n; else fs2 = n; end
         if (n == 1) begin
            chk("first_x", 32'(x), 1);
            chk("first_y", 32'(y), 0);
            chk("first_blank", 32'(blank_n), 0);
         end
         if (n == 2) begin
            chk("lag_blank", 32'(blank_n), 1);
            chk("lag_rgb", 32'({vga_r, vga_g, vga_b}), 32'h00FF8001);
         end
      end
      chk("hs_low_count", hs_lo, 48);
      chk("vs_low_count", vs_lo, 60);
      chk("blank_count", bl, 64);
      chk("rgb_gating", bad, 0);
      chk("hs_first", hs_first, 12);
      chk("vs_first", vs_first, 77);
      chk("blank_fall", bl_fall, 10);
      chk("fs_count", fs_n, 2);
      chk("fs_first", fs1, 120);
      chk("fs_second", fs2, 240);
      chk("wrap_x", 32'(x), 0);
      chk("wrap_y", 32'(y), 0);
      for (int k = 0; k < 240; k++) begin
         pix_en = (k % 2 == 0);
         tick();
         if (frame_start) begin fs_n2++; fs_k = k; end
         if (k == 1) chk("hold_x", 32'(x), 1);
         if (k == 2) chk("adv_x", 32'(x), 2);
      end
      chk("tog_fs_count", fs_n2, 1);
      chk("tog_fs_clk", fs_k, 238);
      pix_en = 1'b1;
      repeat (30) tick();
      scroll_in = 10'd123; scroll_wr = 1'b1;
      tick();
      scroll_wr = 1'b0;
      chk("scroll_wait", 32'(scroll_x), 0);
      repeat (88) tick();
      chk("scroll_prewrap", 32'(scroll_x), 0);
      tick();
      chk("scroll_123", 32'(scroll_x), 123);
      chk("scroll_fs", 32'(frame_start), 1);
      repeat (10) tick();
      scroll_in = 10'd5; scroll_wr = 1'b1;
      tick();
      scroll_wr = 1'b0;
      repeat (5) tick();
      scroll_in = 10'd9; scroll_wr = 1'b1;
      tick();
      scroll_wr = 1'b0;
      chk("scroll_hold", 32'(scroll_x), 123);
      repeat (102) tick();
      chk("scroll_hold2", 32'(scroll_x), 123);
      tick();
      chk("scroll_last", 32'(scroll_x), 9);
      repeat (119) tick();
      scroll_in = 10'd77; scroll_wr = 1'b1;
      tick();
      scroll_wr = 1'b0;
      scroll_in = 10'd500;
      chk("scroll_bypass", 32'(scroll_x), 77);
      repeat (120) tick();
      chk("scroll_stable", 32'(scroll_x), 77);
      repeat (88) tick();
      chk("pre_x", 32'(x), 13);
      chk("pre_y", 32'(y), 5);
      chk("pre_hsync", 32'(hsync), 0);
      chk("pre_vsync", 32'(vsync), 0);
      #1 rst_n = 1'b0;
      #1;
      chk("arst_hsync", 32'(hsync), 1);
      chk("arst_vsync", 32'(vsync), 1);
      chk("arst_x", 32'(x), 0);
      chk("arst_y", 32'(y), 0);
      chk("arst_scroll", 32'(scroll_x), 0);
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      chk("restart_x", 32'(x), 1);
      chk("restart_y", 32'(y), 0);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
